// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants, read-tag type and address helpers for the BRAM port arbiter.
package bram_pkg;

    localparam int BRAM_DATA_W     = 32;
    localparam int BRAM_WE_W       = 4;
    localparam int BRAM_DEPTH      = 2048;
    localparam int BRAM_BYTE_SHIFT = 2;

    localparam int MAX_REQ  = 8;
    localparam int REQ_ID_W = $clog2(MAX_REQ);

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
    } rd_tag_t;

    function automatic logic [BRAM_DATA_W-1:0] word_to_byte_addr(input logic [BRAM_DATA_W-1:0] word_addr);
        return word_addr << BRAM_BYTE_SHIFT;
    endfunction

    // (base + off) mod n for base < n and off < n, without a divider.
    function automatic int rr_wrap(input int base, input int off, input int n);
        return ((base + off) >= n) ? (base + off - n) : (base + off);
    endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester-side bus of the BRAM port arbiter: per-requester request and response signals.
interface bram_port_arbiter_if import bram_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 11
) ();

    logic [NUM_REQ-1:0]                  req_valid;
    logic [NUM_REQ-1:0]                  req_ready;
    logic [NUM_REQ-1:0]                  req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0]      req_addr;
    logic [NUM_REQ-1:0][BRAM_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]                  rsp_valid;
    logic [BRAM_DATA_W-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the winner on every grant.
module rr_arbiter import bram_pkg::*; #(
    parameter int NUM_REQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  i_req,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [REQ_ID_W-1:0] o_grant_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [REQ_ID_W-1:0] r_ptr;
    logic                w_found;
    int                  w_cand;

    // First asserted request scanning upward from r_ptr, wrapping; nothing granted in reset.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_cand     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = rr_wrap(int'(r_ptr), i, NUM_REQ);
            if (!rst && !w_found && i_req[IDX_W'(w_cand)]) begin
                o_grant[IDX_W'(w_cand)] = 1'b1;
                o_grant_id              = REQ_ID_W'(w_cand);
                w_found                 = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

    // Pointer advances to the requester after the one just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= REQ_ID_W'(rr_wrap(int'(o_grant_id), 1, NUM_REQ));
        end else begin
            r_ptr <= r_ptr;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one 32-bit BRAM port between NUM_REQ requesters, one access per cycle,
// with read data routed back to the issuer after READ_LATENCY+1 cycles.
module bram_port_arbiter import bram_pkg::*; #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 11,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    bram_port_arbiter_if.slave     req_if,
    output logic [BRAM_DATA_W-1:0] BRAM_addr,
    output logic                   BRAM_clk,
    output logic [BRAM_DATA_W-1:0] BRAM_din,
    input  logic [BRAM_DATA_W-1:0] BRAM_dout,
    output logic                   BRAM_en,
    output logic                   BRAM_rst,
    output logic [BRAM_WE_W-1:0]   BRAM_we
);

    logic [NUM_REQ-1:0]     w_grant;
    logic [REQ_ID_W-1:0]    w_grant_id;
    logic                   w_hs;
    logic                   w_sel_we;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [BRAM_DATA_W-1:0] w_sel_wdata;

    logic                   r_en;
    logic [BRAM_WE_W-1:0]   r_we;
    logic [BRAM_DATA_W-1:0] r_addr;
    logic [BRAM_DATA_W-1:0] r_din;
    rd_tag_t                r_tag [READ_LATENCY+1];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req_if.req_valid),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign req_if.req_ready = w_grant;
    assign w_hs             = |w_grant;

    // One-hot grant lets the request fields be selected with an AND-OR mux.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_we    = w_sel_we    | (w_grant[i] & req_if.req_we[i]);
            w_sel_addr  = w_sel_addr  | ({ADDR_W{w_grant[i]}} & req_if.req_addr[i]);
            w_sel_wdata = w_sel_wdata | ({BRAM_DATA_W{w_grant[i]}} & req_if.req_wdata[i]);
        end
    end

    // Accepted transaction is registered onto the BRAM port for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_en   <= 1'b0;
            r_we   <= {BRAM_WE_W{1'b0}};
            r_addr <= {BRAM_DATA_W{1'b0}};
            r_din  <= {BRAM_DATA_W{1'b0}};
        end else begin
            r_en <= w_hs;
            r_we <= {BRAM_WE_W{w_hs & w_sel_we}};
            if (w_hs) begin
                r_addr <= word_to_byte_addr(BRAM_DATA_W'(w_sel_addr));
                r_din  <= w_sel_wdata;
            end else begin
                r_addr <= r_addr;
                r_din  <= r_din;
            end
        end
    end

    // Read tags travel alongside the BRAM latency so data returns to its issuer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= READ_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_tag[0] <= '{valid: w_hs & ~w_sel_we, id: w_grant_id};
            for (int k = 1; k <= READ_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Reset masks the port immediately so nothing in flight leaks out while rst is high.
    assign BRAM_clk  = clk;
    assign BRAM_rst  = rst;
    assign BRAM_en   = r_en & ~rst;
    assign BRAM_we   = rst ? {BRAM_WE_W{1'b0}}   : r_we;
    assign BRAM_addr = rst ? {BRAM_DATA_W{1'b0}} : r_addr;
    assign BRAM_din  = rst ? {BRAM_DATA_W{1'b0}} : r_din;

    // Response strobe is decoded from the oldest tag; data is forced to zero when idle.
    always_comb begin
        req_if.rsp_valid = '0;
        req_if.rsp_rdata = {BRAM_DATA_W{1'b0}};
        if (!rst && r_tag[READ_LATENCY].valid) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_if.rsp_valid[i] = (r_tag[READ_LATENCY].id == REQ_ID_W'(i));
            end
            req_if.rsp_rdata = BRAM_dout;
        end else begin
            req_if.rsp_valid = '0;
            req_if.rsp_rdata = {BRAM_DATA_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench: two arbiters (READ_LATENCY 1 and 2), each driving its own behavioural BRAM.
module tb_bram_port_arbiter;
    import bram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    bram_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(11)) bus1 ();
    bram_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(11)) bus2 ();

    logic [31:0] b1_addr, b1_din, b1_dout;
    logic [31:0] b2_addr, b2_din, b2_dout;
    logic        b1_clk, b1_en, b1_rst, b2_clk, b2_en, b2_rst;
    logic [3:0]  b1_we, b2_we;

    bram_port_arbiter #(.NUM_REQ(2), .ADDR_W(11), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_if(bus1),
        .BRAM_addr(b1_addr), .BRAM_clk(b1_clk), .BRAM_din(b1_din), .BRAM_dout(b1_dout),
        .BRAM_en(b1_en), .BRAM_rst(b1_rst), .BRAM_we(b1_we)
    );

    bram_port_arbiter #(.NUM_REQ(2), .ADDR_W(11), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_if(bus2),
        .BRAM_addr(b2_addr), .BRAM_clk(b2_clk), .BRAM_din(b2_din), .BRAM_dout(b2_dout),
        .BRAM_en(b2_en), .BRAM_rst(b2_rst), .BRAM_we(b2_we)
    );

    // Behavioural BRAMs with a side preload path driven by the bench.
    logic [31:0] mem1 [2048];
    logic [31:0] mem2 [2048];
    logic [31:0] m2_d1;
    logic        pl_en1, pl_en2;
    logic [10:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge b1_clk) begin
        if (pl_en1) mem1[pl_addr] <= pl_data;
        else if (b1_en && b1_we == 4'hF) mem1[b1_addr[12:2]] <= b1_din;
        if (b1_en) b1_dout <= mem1[b1_addr[12:2]];
    end

    always @(posedge b2_clk) begin
        if (pl_en2) mem2[pl_addr] <= pl_data;
        else if (b2_en && b2_we == 4'hF) mem2[b2_addr[12:2]] <= b2_din;
        if (b2_en) m2_d1 <= mem2[b2_addr[12:2]];
        b2_dout <= m2_d1;
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic preload(input logic sel2, input logic [10:0] a, input logic [31:0] d);
        next_cycle();
        pl_en1 = ~sel2; pl_en2 = sel2; pl_addr = a; pl_data = d;
        next_cycle();
        pl_en1 = 1'b0; pl_en2 = 1'b0;
    endtask

    task automatic idle_bus();
        bus1.req_valid = 2'b00; bus1.req_we = 2'b00;
        bus2.req_valid = 2'b00; bus2.req_we = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_bus();
        repeat (3) next_cycle();
        bus1.req_valid = 2'b11;
        bus2.req_valid = 2'b11;
        #1;
        n_cmp++; if (bus1.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready1: got %b want %b", bus1.req_ready, 2'b00); end
        n_cmp++; if (bus2.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready2: got %b want %b", bus2.req_ready, 2'b00); end
        n_cmp++; if (bus1.rsp_valid !== 2'b00 || bus1.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rsp: got %b/%h want 00/0", bus1.rsp_valid, bus1.rsp_rdata); end
        n_cmp++; if (b1_en !== 1'b0 || b1_we !== 4'h0) begin n_fail++; $display("FAIL rst_en_we: got %b/%h want 0/0", b1_en, b1_we); end
        n_cmp++; if (b1_addr !== 32'h0 || b1_din !== 32'h0) begin n_fail++; $display("FAIL rst_addr_din: got %h/%h want 0/0", b1_addr, b1_din); end
        next_cycle();
        rst = 1'b0;
        idle_bus();
    endtask

    task automatic test_read();
        next_cycle();
        bus1.req_valid = 2'b01; bus1.req_we = 2'b00; bus1.req_addr[0] = 11'h005;
        #1;
        n_cmp++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL rd_ready: got %b want %b", bus1.req_ready, 2'b01); end
        next_cycle();
        bus1.req_valid = 2'b00;
        #1;
        n_cmp++; if (b1_en !== 1'b1 || b1_addr !== 32'h14 || b1_we !== 4'h0) begin n_fail++; $display("FAIL rd_port: got en=%b addr=%h we=%h want 1/00000014/0", b1_en, b1_addr, b1_we); end
        n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rd_early_rsp: got %b want %b", bus1.rsp_valid, 2'b00); end
        next_cycle();
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b01 || bus1.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp: got %b/%h want 01/deadbeef", bus1.rsp_valid, bus1.rsp_rdata); end
        n_cmp++; if (b1_en !== 1'b0) begin n_fail++; $display("FAIL rd_idle_en: got %b want 0", b1_en); end
        next_cycle();
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b00 || bus1.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_rsp_clear: got %b/%h want 00/0", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    task automatic test_write_then_read();
        next_cycle();
        bus1.req_valid = 2'b10; bus1.req_we = 2'b10;
        bus1.req_addr[1] = 11'h7FF; bus1.req_wdata[1] = 32'h12345678;
        #1;
        n_cmp++; if (bus1.req_ready !== 2'b10) begin n_fail++; $display("FAIL wr_ready: got %b want %b", bus1.req_ready, 2'b10); end
        next_cycle();
        bus1.req_valid = 2'b00; bus1.req_we = 2'b00;
        #1;
        n_cmp++; if (b1_en !== 1'b1 || b1_addr !== 32'h1FFC || b1_we !== 4'hF || b1_din !== 32'h12345678) begin
            n_fail++; $display("FAIL wr_port: got en=%b addr=%h we=%h din=%h want 1/00001ffc/f/12345678", b1_en, b1_addr, b1_we, b1_din);
        end
        next_cycle();
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL wr_no_rsp: got %b want %b", bus1.rsp_valid, 2'b00); end
        bus1.req_valid = 2'b01; bus1.req_addr[0] = 11'h7FF;
        #1;
        n_cmp++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL raw_ready: got %b want %b", bus1.req_ready, 2'b01); end
        next_cycle();
        bus1.req_valid = 2'b00;
        next_cycle();
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b01 || bus1.rsp_rdata !== 32'h12345678) begin n_fail++; $display("FAIL raw_rsp: got %b/%h want 01/12345678", bus1.rsp_valid, bus1.rsp_rdata); end
    endtask

    task automatic test_alternate();
        int hs0;
        int hs1;
        logic [1:0] exp_g;
        hs0 = 0; hs1 = 0;
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            bus1.req_valid = 2'b11; bus1.req_we = 2'b00;
            bus1.req_addr[0] = 11'h001; bus1.req_addr[1] = 11'h002;
            #1;
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            n_cmp++; if (bus1.req_ready !== exp_g) begin n_fail++; $display("FAIL alt_grant[%0d]: got %b want %b", c, bus1.req_ready, exp_g); end
            if (bus1.req_ready[0] === 1'b1) hs0++;
            if (bus1.req_ready[1] === 1'b1) hs1++;
        end
        next_cycle();
        idle_bus();
        n_cmp++; if (hs0 != 3 || hs1 != 3) begin n_fail++; $display("FAIL alt_counts: got %0d/%0d want 3/3", hs0, hs1); end
        repeat (3) next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d;
        for (int i = 0; i < 8; i++) preload(1'b0, 11'(i), 32'hA000_0000 + 32'(i));
        for (int c = 0; c < 11; c++) begin
            next_cycle();
            if (c < 8) begin
                bus1.req_valid = 2'b01; bus1.req_we = 2'b00; bus1.req_addr[0] = 11'(c);
            end else begin
                bus1.req_valid = 2'b00;
            end
            #1;
            if (c < 8) begin
                n_cmp++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", c, bus1.req_ready, 2'b01); end
            end
            if (c >= 2 && c <= 9) begin
                exp_d = 32'hA000_0000 + 32'(c - 2);
                n_cmp++; if (bus1.rsp_valid !== 2'b01 || bus1.rsp_rdata !== exp_d) begin n_fail++; $display("FAIL b2b_rsp[%0d]: got %b/%h want 01/%h", c, bus1.rsp_valid, bus1.rsp_rdata, exp_d); end
            end
            if (c == 10) begin
                n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL b2b_tail: got %b want %b", bus1.rsp_valid, 2'b00); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        next_cycle();
        bus1.req_valid = 2'b01; bus1.req_we = 2'b00; bus1.req_addr[0] = 11'h003;
        next_cycle();
        bus1.req_addr[0] = 11'h004;
        next_cycle();
        rst = 1'b1; bus1.req_valid = 2'b11;
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_rsp_in_rst: got %b want %b", bus1.rsp_valid, 2'b00); end
        n_cmp++; if (bus1.req_ready !== 2'b00 || b1_en !== 1'b0) begin n_fail++; $display("FAIL mid_ready_en: got %b/%b want 00/0", bus1.req_ready, b1_en); end
        next_cycle();
        rst = 1'b0; bus1.req_valid = 2'b00;
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b00 || b1_en !== 1'b0) begin n_fail++; $display("FAIL mid_after1: got %b/%b want 00/0", bus1.rsp_valid, b1_en); end
        next_cycle();
        #1;
        n_cmp++; if (bus1.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_after2: got %b want %b", bus1.rsp_valid, 2'b00); end
        bus1.req_valid = 2'b11;
        #1;
        n_cmp++; if (bus1.req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_ptr_reset: got %b want %b", bus1.req_ready, 2'b01); end
        next_cycle();
        idle_bus();
        repeat (2) next_cycle();
    endtask

    task automatic test_latency2();
        preload(1'b1, 11'h003, 32'h3333_3333);
        preload(1'b1, 11'h009, 32'h9999_9999);
        preload(1'b1, 11'h004, 32'h4444_4444);
        next_cycle();
        bus2.req_valid = 2'b11; bus2.req_we = 2'b00;
        bus2.req_addr[0] = 11'h003; bus2.req_addr[1] = 11'h009;
        #1;
        n_cmp++; if (bus2.req_ready !== 2'b01) begin n_fail++; $display("FAIL rl2_g0: got %b want %b", bus2.req_ready, 2'b01); end
        next_cycle();
        bus2.req_valid = 2'b10;
        #1;
        n_cmp++; if (bus2.req_ready !== 2'b10) begin n_fail++; $display("FAIL rl2_g1: got %b want %b", bus2.req_ready, 2'b10); end
        next_cycle();
        bus2.req_valid = 2'b01; bus2.req_addr[0] = 11'h004;
        #1;
        n_cmp++; if (bus2.req_ready !== 2'b01 || bus2.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rl2_g2: got %b/%b want 01/00", bus2.req_ready, bus2.rsp_valid); end
        next_cycle();
        bus2.req_valid = 2'b00;
        #1;
        n_cmp++; if (bus2.rsp_valid !== 2'b01 || bus2.rsp_rdata !== 32'h3333_3333) begin n_fail++; $display("FAIL rl2_r0: got %b/%h want 01/33333333", bus2.rsp_valid, bus2.rsp_rdata); end
        next_cycle();
        #1;
        n_cmp++; if (bus2.rsp_valid !== 2'b10 || bus2.rsp_rdata !== 32'h9999_9999) begin n_fail++; $display("FAIL rl2_r1: got %b/%h want 10/99999999", bus2.rsp_valid, bus2.rsp_rdata); end
        next_cycle();
        #1;
        n_cmp++; if (bus2.rsp_valid !== 2'b01 || bus2.rsp_rdata !== 32'h4444_4444) begin n_fail++; $display("FAIL rl2_r2: got %b/%h want 01/44444444", bus2.rsp_valid, bus2.rsp_rdata); end
        next_cycle();
        #1;
        n_cmp++; if (bus2.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rl2_tail: got %b want %b", bus2.rsp_valid, 2'b00); end
    endtask

    initial begin
        rst = 1'b1;
        pl_en1 = 1'b0; pl_en2 = 1'b0; pl_addr = 11'h0; pl_data = 32'h0;
        idle_bus();
        bus1.req_addr = '0; bus1.req_wdata = '0;
        bus2.req_addr = '0; bus2.req_wdata = '0;
        test_reset();
        preload(1'b0, 11'h005, 32'hDEADBEEF);
        test_read();
        test_write_then_read();
        test_alternate();
        test_back_to_back();
        test_reset_midflight();
        test_latency2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single 32-bit PS-visible BRAM port between NUM_REQ fabric requesters, e.g. the sequence/wavetable writer and the audio playback reader.
- Each requester issues one-word read or write transactions over a valid/ready handshake.
- Requesters are served round-robin, one access per cycle.
- Read data is returned to the issuing requester with a fixed latency.
- Drives the BRAM_* pins that are currently tied directly to a single writer.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 11, word-address width (2048-word BRAM).
- READ_LATENCY, 1, BRAM clock-to-dout latency in cycles (1..3).

Ports:
- clk  in  1  system clock; also forwarded as BRAM_clk.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester transaction valid.
- req_ready  out  NUM_REQ  per-requester grant; the handshake completes when valid & ready.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x ADDR_W  word address.
- req_wdata  in  NUM_REQ x 32  write data.
- rsp_valid  out  NUM_REQ  one-cycle read-response strobe, one-hot.
- rsp_rdata  out  32  read data, shared by all requesters, qualified by rsp_valid.
- BRAM_addr  out  32  byte address.
- BRAM_clk  out  1  = clk.
- BRAM_din  out  32  write data.
- BRAM_dout  in  32  read data.
- BRAM_en  out  1  port enable.
- BRAM_rst  out  1  = rst.
- BRAM_we  out  4  byte write enables.

Behaviour:

Reset
- During and after rst: req_ready = 0, rsp_valid = 0, rsp_rdata = 0.
- BRAM_en = 0, BRAM_we = 0, BRAM_addr = 0, BRAM_din = 0.
- rr_ptr = 0; the read-tag pipeline is cleared.

Arbitration
- The grant is combinational: the first asserted req_valid scanning from rr_ptr upward, with wrap-around.
- req_ready[i] = grant[i]. At most one grant per cycle.
- req_ready may depend on req_valid. Requesters must not make valid depend on ready.
- req_valid, once high, holds with stable we/addr/wdata until accepted.

Pointer update
- On a handshake by requester g: rr_ptr <= (g+1) mod NUM_REQ.
- No handshake: rr_ptr holds.
- Consequence: two continuously requesting masters alternate every cycle; a lone requester gets 100% throughput.

Issue
- Handshake in cycle T, registered into the BRAM port and driven during T+1:
  - BRAM_en = 1.
  - BRAM_addr = {zero-pad, addr, 2'b00} (word << 2).
  - BRAM_din = wdata.
  - BRAM_we = {4{we}}.
- No handshake in T: BRAM_en = 0 and BRAM_we = 0 in T+1. addr/din may hold their previous value.

Read return
- Each accepted read pushes {valid, requester id} into a READ_LATENCY+1 deep shift register.
- rsp_valid[id] = 1 and rsp_rdata = BRAM_dout in cycle T+1+READ_LATENCY. Total handshake-to-response latency is READ_LATENCY+1 cycles.
- Back-to-back reads produce back-to-back responses in order.
- Writes produce no response.
- rsp_rdata is 0 when no rsp_valid bit is set.

Boundary conditions
- Simultaneous read and write requests from different requesters: serialized by round-robin. There is no read/write priority.
- Write followed by read of the same address from another requester in the next accepted slot: the read returns the new data (BRAM write-first/read-after-write is in a later cycle).
- Highest address (2^ADDR_W-1) maps to byte address 0x1FFC. No wrap logic inside this block.
- rst asserted mid-operation: in-flight reads are dropped (tags cleared) and no rsp_valid is asserted for them after reset. The BRAM port is idle in the cycle after rst.
- All requesters idle: the port stays idle (BRAM_en = 0).

Decomposition:
- Package bram_pkg:
  - BRAM_DATA_W = 32, BRAM_WE_W = 4, BRAM_DEPTH = 2048, BRAM_BYTE_SHIFT = 2.
  - typedef rd_tag_t, a struct {logic valid; logic [$clog2(NUM_REQ)-1:0] id} sized by a max-requester constant.
- One sub-module rr_arbiter: the parameterised combinational round-robin grant plus the rr_ptr register and its update.
- The tag pipeline and port registers stay in the top module.

Test Plan:
- Requester 0 reads addr 0x005 after BRAM preloaded with 0xDEADBEEF -> BRAM_en = 1, BRAM_addr = 0x14, BRAM_we = 0 in T+1; rsp_valid = 2'b01 and rsp_rdata = 0xDEADBEEF in T+2 (READ_LATENCY = 1).
- Requester 1 writes 0x12345678 to addr 0x7FF -> T+1: BRAM_addr = 0x1FFC, BRAM_we = 4'hF, BRAM_din = 0x12345678; no rsp_valid. A later read by requester 0 returns 0x12345678.
- Both requesters hold valid for 6 cycles from reset -> grants 0,1,0,1,0,1; each sees exactly 3 handshakes.
- Requester 0 alone issues 8 back-to-back reads of addrs 0..7 -> ready high all 8 cycles; 8 consecutive rsp_valid pulses with data in address order.
- Two reads accepted, then rst pulsed in the following cycle -> no rsp_valid for either read; req_ready = 0, BRAM_en = 0 during reset; rr_ptr back to 0 (requester 0 wins the first contention after reset).
- READ_LATENCY = 2 build, interleaved reads from requesters 0 and 1 -> each response arrives exactly 3 cycles after its handshake, with the matching rsp_valid bit.
